// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like request interface: size codes,
// responder state encoding and the byte-lane write mask used by the caches too.
package sram_like_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AWAIT = 2'd1,
        ST_DWAIT = 2'd2
    } state_e;

    // Size code 2'b11 is treated as a full word.
    function automatic logic [3:0] wmask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: wmask = 4'b0001 << addr_lo;
            SZ_HALF: wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: wmask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sram_like_ram_array.sv
// Word-organised RAM, one 8-bit bank per byte lane, per-lane write enables
// and a combinational read port shared with the write address.
module sram_like_ram_array
    import sram_like_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [3:0]            i_be,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_we && i_be[gi]) begin
                    r_mem[i_addr] <= i_wdata[gi*8 +: 8];
                end
            end

            assign o_rdata[gi*8 +: 8] = r_mem[i_addr];
        end
    endgenerate

endmodule

// File: rtl/sram_like_ram_slave.sv
// SRAM-like responder backed by a local RAM, with programmable address-accept
// and data-return latency; one outstanding transaction, back-to-back capable.
module sram_like_ram_slave
    import sram_like_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int ADDR_LAT   = 0,
    parameter int DATA_LAT   = 1
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_addr_ok,
    output logic        o_data_ok
);

    localparam int ACW = $clog2(ADDR_LAT + 2);
    localparam int DCW = $clog2(DATA_LAT + 2);

    state_e                r_state, w_state_next;
    logic [ACW-1:0]        r_acnt, w_acnt_next;
    logic [DCW-1:0]        r_dcnt, w_dcnt_next;
    logic                  r_wr;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  w_addr_ok;
    logic                  w_data_ok;
    logic [3:0]            w_be;
    logic [31:0]           w_ram_rdata;
    logic                  w_unused_addr;

    // Upper address bits alias onto the same RAM words.
    assign w_unused_addr = ^i_addr[31:ADDR_WIDTH+2];

    always_comb begin
        w_state_next = r_state;
        w_acnt_next  = r_acnt;
        w_dcnt_next  = r_dcnt;
        w_addr_ok    = 1'b0;
        w_data_ok    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    if (ADDR_LAT == 0) begin
                        w_addr_ok    = 1'b1;
                        w_state_next = ST_DWAIT;
                        w_dcnt_next  = DCW'(1);
                    end else begin
                        w_state_next = ST_AWAIT;
                        w_acnt_next  = ACW'(1);
                    end
                end
            end
            ST_AWAIT: begin
                if (!i_req) begin
                    w_state_next = ST_IDLE;
                    w_acnt_next  = '0;
                end else if (r_acnt == ACW'(ADDR_LAT)) begin
                    w_addr_ok    = 1'b1;
                    w_state_next = ST_DWAIT;
                    w_acnt_next  = '0;
                    w_dcnt_next  = DCW'(1);
                end else begin
                    w_acnt_next = r_acnt + ACW'(1);
                end
            end
            ST_DWAIT: begin
                if (r_dcnt == DCW'(DATA_LAT)) begin
                    w_data_ok = 1'b1;
                    // A zero-latency accept can overlap the completing transaction.
                    if (ADDR_LAT == 0 && i_req) begin
                        w_addr_ok   = 1'b1;
                        w_dcnt_next = DCW'(1);
                    end else begin
                        w_state_next = ST_IDLE;
                        w_dcnt_next  = '0;
                    end
                end else begin
                    w_dcnt_next = r_dcnt + DCW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_acnt_next  = '0;
                w_dcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
            r_acnt  <= '0;
            r_dcnt  <= '0;
            r_wr    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_acnt  <= w_acnt_next;
            r_dcnt  <= w_dcnt_next;
            if (w_addr_ok) begin
                r_wr    <= i_wr;
                r_size  <= i_size;
                r_addr  <= i_addr[ADDR_WIDTH+1:0];
                r_wdata <= i_wdata;
            end
        end
    end

    assign w_be = wmask(r_size, r_addr[1:0]);

    // The write lands on the edge closing the data_ok cycle.
    sram_like_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_data_ok & r_wr),
        .i_be    (w_be),
        .i_addr  (r_addr[ADDR_WIDTH+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign o_addr_ok = w_addr_ok & i_resetn;
    assign o_data_ok = w_data_ok;
    assign o_rdata   = (w_data_ok && !r_wr) ? w_ram_rdata : 32'h0;

endmodule
